// File: rtl/mtr_ebus_host_if.sv
// Command/response handshake between the microcode side and the meter host.
// The master modport is the requester; the slave modport is mtr_ebus_host.
interface mtr_ebus_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [2:0]  cmd_func;
  logic [17:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_read, cmd_func, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_func, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mtr_ebus_host.sv
// EBOX-side initiator for the M8538 meter board: SPEC MTR CTL writes, READ MTR
// reads, and autonomous interrupt service (hold word, then selected counter).
module mtr_ebus_host #(
  parameter int unsigned RD_WAIT  = 3,
  parameter int unsigned WR_HOLD  = 2,
  parameter bit          AUTO_SVC = 1'b1
) (
  input  logic           clk,
  input  logic           RESET_L,
  mtr_ebus_host_if.slave hbus,
  output logic           SPEC_MTR_CTL,
  output logic [2:0]     MAGIC,
  output logic           READ_MTR,
  output logic [2:0]     DIAG,
  output logic           ebus_drive,
  output logic [17:0]    ebus_out,
  input  logic [15:0]    ebus_in,
  input  logic           INTERRUPT_REQ,
  output logic           irq_valid,
  output logic           irq_vector,
  output logic [1:0]     irq_sel,
  output logic [15:0]    irq_data,
  output logic           irq_pending
);

  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_SETUP, S_WR_STB, S_WR_HOLD, S_RD_SEL, S_RD_WAIT, S_RD_CAP
  } state_t;

  typedef enum logic [1:0] {TAG_CMD, TAG_IRQ_HOLD, TAG_IRQ_CNT} tag_t;

  state_t        state, state_nxt;
  tag_t          tag, tag_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    diag_q, diag_nxt;
  logic [2:0]    func_q;
  logic [17:0]   data_q;
  logic [15:0]   cap_q;
  logic [1:0]    sel_q;
  logic [1:0]    hold_sel;
  logic          pending;
  logic          accept;
  logic          cap_en;
  logic          sel_en;

  // Hold word: EBUS bit 20 (ebus_in[15]) is the vector flag; INCR_SEL has bit 22 as its MSB.
  assign hold_sel    = {cap_q[13], cap_q[14]};
  assign DIAG        = diag_q;
  assign irq_sel     = sel_q;
  assign irq_pending = pending;

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state  <= S_IDLE;
      tag    <= TAG_CMD;
      cnt    <= '0;
      diag_q <= '0;
    end else begin
      state  <= state_nxt;
      tag    <= tag_nxt;
      cnt    <= cnt_nxt;
      diag_q <= diag_nxt;
    end
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      func_q  <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      sel_q   <= '0;
      pending <= 1'b0;
    end else begin
      if (accept) begin
        func_q <= hbus.cmd_func;
        data_q <= hbus.cmd_data;
      end
      if (cap_en) cap_q <= ebus_in;
      if (sel_en) sel_q <= hold_sel;
      // Clearing wins for one cycle so a still-high request re-arms on the next edge.
      if (irq_valid)          pending <= 1'b0;
      else if (INTERRUPT_REQ) pending <= 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    tag_nxt        = tag;
    cnt_nxt        = cnt;
    diag_nxt       = diag_q;
    accept         = 1'b0;
    cap_en         = 1'b0;
    sel_en         = 1'b0;
    hbus.cmd_ready = 1'b0;
    hbus.rsp_valid = 1'b0;
    hbus.rsp_data  = '0;
    hbus.rsp_err   = 1'b0;
    SPEC_MTR_CTL   = 1'b0;
    MAGIC          = '0;
    READ_MTR       = 1'b0;
    ebus_drive     = 1'b0;
    ebus_out       = '0;
    irq_valid      = 1'b0;
    irq_vector     = 1'b0;
    irq_data       = '0;

    unique case (state)
      S_IDLE: begin
        if (AUTO_SVC && pending) begin
          state_nxt = S_RD_SEL;
          tag_nxt   = TAG_IRQ_HOLD;
          diag_nxt  = 3'd7;
        end else if (hbus.cmd_valid) begin
          hbus.cmd_ready = 1'b1;
          accept         = 1'b1;
          tag_nxt        = TAG_CMD;
          if (hbus.cmd_read) begin
            state_nxt = S_RD_SEL;
            diag_nxt  = hbus.cmd_func;
          end else begin
            state_nxt = S_WR_SETUP;
          end
        end
      end
      S_WR_SETUP: begin
        if (func_q == '0) begin
          hbus.rsp_valid = 1'b1;
          hbus.rsp_err   = 1'b1;
          state_nxt      = S_IDLE;
        end else begin
          ebus_drive = 1'b1;
          ebus_out   = data_q;
          MAGIC      = func_q;
          state_nxt  = S_WR_STB;
        end
      end
      S_WR_STB: begin
        ebus_drive   = 1'b1;
        ebus_out     = data_q;
        MAGIC        = func_q;
        SPEC_MTR_CTL = 1'b1;
        cnt_nxt      = CW'(WR_HOLD - 1);
        state_nxt    = S_WR_HOLD;
      end
      S_WR_HOLD: begin
        ebus_drive = 1'b1;
        ebus_out   = data_q;
        MAGIC      = func_q;
        if (cnt == '0) begin
          hbus.rsp_valid = 1'b1;
          state_nxt      = S_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_RD_SEL: begin
        READ_MTR  = 1'b1;
        cnt_nxt   = CW'(RD_WAIT - 1);
        state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        READ_MTR = 1'b1;
        if (cnt == '0) begin
          cap_en    = 1'b1;
          state_nxt = S_RD_CAP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_RD_CAP: begin
        state_nxt = S_IDLE;
        unique case (tag)
          TAG_CMD: begin
            hbus.rsp_valid = 1'b1;
            hbus.rsp_data  = cap_q;
          end
          TAG_IRQ_HOLD: begin
            if (cap_q[15]) begin
              irq_valid  = 1'b1;
              irq_vector = 1'b1;
            end else begin
              sel_en    = 1'b1;
              tag_nxt   = TAG_IRQ_CNT;
              diag_nxt  = {1'b0, hold_sel};
              state_nxt = S_RD_SEL;
            end
          end
          TAG_IRQ_CNT: begin
            irq_valid = 1'b1;
            irq_data  = cap_q;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mtr_ebus_host.sv
// Directed bench for mtr_ebus_host: stimulus pushes expected responses into a
// queue, a negedge monitor pops and compares them when rsp_valid/irq_valid fire.
module tb_mtr_ebus_host;

  logic        clk = 1'b0;
  logic        RESET_L;
  logic        SPEC_MTR_CTL, READ_MTR, ebus_drive;
  logic [2:0]  MAGIC, DIAG;
  logic [17:0] ebus_out;
  logic [15:0] ebus_in = '0;
  logic        INTERRUPT_REQ;
  logic        irq_valid, irq_vector, irq_pending;
  logic [1:0]  irq_sel;
  logic [15:0] irq_data;

  logic        SPEC_MTR_CTL1, READ_MTR1, ebus_drive1;
  logic [2:0]  MAGIC1, DIAG1;
  logic [17:0] ebus_out1;
  logic [15:0] ebus_in1 = '0;
  logic        INTERRUPT_REQ1;
  logic        irq_valid1, irq_vector1, irq_pending1;
  logic [1:0]  irq_sel1;
  logic [15:0] irq_data1;

  mtr_ebus_host_if hb ();
  mtr_ebus_host_if hb1 ();

  mtr_ebus_host #(.RD_WAIT(3), .WR_HOLD(2), .AUTO_SVC(1'b1)) u_dut (
    .clk(clk), .RESET_L(RESET_L), .hbus(hb),
    .SPEC_MTR_CTL(SPEC_MTR_CTL), .MAGIC(MAGIC), .READ_MTR(READ_MTR), .DIAG(DIAG),
    .ebus_drive(ebus_drive), .ebus_out(ebus_out), .ebus_in(ebus_in),
    .INTERRUPT_REQ(INTERRUPT_REQ), .irq_valid(irq_valid), .irq_vector(irq_vector),
    .irq_sel(irq_sel), .irq_data(irq_data), .irq_pending(irq_pending)
  );

  mtr_ebus_host #(.RD_WAIT(3), .WR_HOLD(2), .AUTO_SVC(1'b0)) u_nosvc (
    .clk(clk), .RESET_L(RESET_L), .hbus(hb1),
    .SPEC_MTR_CTL(SPEC_MTR_CTL1), .MAGIC(MAGIC1), .READ_MTR(READ_MTR1), .DIAG(DIAG1),
    .ebus_drive(ebus_drive1), .ebus_out(ebus_out1), .ebus_in(ebus_in1),
    .INTERRUPT_REQ(INTERRUPT_REQ1), .irq_valid(irq_valid1), .irq_vector(irq_vector1),
    .irq_sel(irq_sel1), .irq_data(irq_data1), .irq_pending(irq_pending1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_irq;
    logic [15:0] data;
    bit          err;
    bit          vec;
    logic [1:0]  sel;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0, failures = 0;
  int          cyc = 0;
  int          spec_cyc = 0, rd_cyc = 0, drv_cyc = 0, viol = 0, rd1 = 0, iv1 = 0;
  logic [11:0] hist = '0;
  logic        rd_prev = 1'b0;
  logic [15:0] mem [8];
  logic [20:0] act_v, exp_v;

  always @(posedge clk) cyc <= cyc + 1;

  // Meter model: registered EBUS read path selected by DIAG.
  always @(posedge clk) ebus_in <= READ_MTR ? mem[DIAG] : '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_irq, input logic [15:0] data, input bit err,
                          input bit vec, input logic [1:0] sel, input int due);
    exp_t x;
    x.is_irq = is_irq; x.data = data; x.err = err; x.vec = vec; x.sel = sel; x.due = due;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (RESET_L) begin
      if (hb.rsp_valid && irq_valid) viol++;
      if (READ_MTR && ebus_drive) viol++;
      if (SPEC_MTR_CTL) spec_cyc++;
      if (READ_MTR) rd_cyc++;
      if (ebus_drive) drv_cyc++;
      if (READ_MTR && !rd_prev) hist = {hist[8:0], DIAG};
      rd_prev = READ_MTR;
      if (READ_MTR1) rd1++;
      if (irq_valid1) iv1++;
      if (hb.rsp_valid || irq_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_response", 64'(cyc), 64'(-1));
        end else begin
          e = sb.pop_front();
          if (irq_valid)
            act_v = {1'b1, irq_data, 1'b0, irq_vector, (irq_vector ? 2'b00 : irq_sel)};
          else
            act_v = {1'b0, hb.rsp_data, hb.rsp_err, 2'b00, 1'b0};
          exp_v = {e.is_irq, e.data, e.err, e.vec, e.sel};
          chk(e.is_irq ? "irq_result" : "rsp_result", 64'(act_v), 64'(exp_v));
          chk("response_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end else begin
      rd_prev = 1'b0;
    end
  end

  task automatic send(input bit rd, input logic [2:0] f, input logic [17:0] d, input bit push,
                      input int lat, input logic [15:0] xdata, input bit xerr, output int acc);
    int n;
    hb.cmd_valid = 1'b1;
    hb.cmd_read  = rd;
    hb.cmd_func  = f;
    hb.cmd_data  = d;
    acc = -1;
    n   = 0;
    while (acc < 0 && n < 200) begin
      @(negedge clk);
      if (hb.cmd_ready) acc = cyc;
      n++;
    end
    if (acc < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=none required=cmd_ready within 200 cycles");
    end else if (push) begin
      push_exp(1'b0, xdata, xerr, 1'b0, 2'b00, acc + lat);
    end
    @(posedge clk); #1;
    hb.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, r, s0, d0, r0;
    RESET_L = 1'b0;
    hb.cmd_valid = 1'b0; hb.cmd_read = 1'b0; hb.cmd_func = '0; hb.cmd_data = '0;
    hb1.cmd_valid = 1'b0; hb1.cmd_read = 1'b0; hb1.cmd_func = '0; hb1.cmd_data = '0;
    INTERRUPT_REQ = 1'b0;
    INTERRUPT_REQ1 = 1'b0;
    mem[0] = 16'hBEEF; mem[1] = 16'h1111; mem[2] = 16'h7FFF; mem[3] = 16'h3333;
    mem[4] = 16'h0123; mem[5] = 16'h5555; mem[6] = 16'h6666; mem[7] = 16'hFFFF;

    repeat (3) @(posedge clk); #1;
    chk("reset_outputs",
        64'({SPEC_MTR_CTL, READ_MTR, ebus_drive, hb.rsp_valid, hb.cmd_ready, irq_valid,
             irq_pending, MAGIC, DIAG, ebus_out}), 64'(0));
    @(negedge clk) RESET_L = 1'b1;
    @(posedge clk); #1;

    // Flag-only instance: request is remembered, never serviced.
    INTERRUPT_REQ1 = 1'b1;
    repeat (2) @(posedge clk); #1;
    INTERRUPT_REQ1 = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("nosvc_pending", 64'(irq_pending1), 64'(1));
    chk("nosvc_no_read", 64'(rd1), 64'(0));
    chk("nosvc_no_irq", 64'(iv1), 64'(0));

    // CONO_TIM-style write, func 7.
    s0 = spec_cyc; d0 = drv_cyc;
    send(1'b0, 3'd7, 18'o400144, 1'b1, 4, 16'h0000, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    chk("wr_strobe", 64'({SPEC_MTR_CTL, ebus_drive, MAGIC}), 64'({1'b1, 1'b1, 3'd7}));
    @(negedge clk);
    @(negedge clk);
    chk("wr_hold", 64'({ebus_drive, SPEC_MTR_CTL, MAGIC, ebus_out}),
        64'({1'b1, 1'b0, 3'd7, 18'o400144}));
    drain();
    chk("wr_strobe_cycles", 64'(spec_cyc - s0), 64'(1));
    chk("wr_drive_cycles", 64'(drv_cyc - d0), 64'(4));

    // Read func 4.
    r0 = rd_cyc; hist = '0;
    send(1'b1, 3'd4, 18'o0, 1'b1, 5, 16'h0123, 1'b0, acc);
    drain();
    chk("rd_cycles", 64'(rd_cyc - r0), 64'(4));
    chk("rd_diag", 64'(hist), 64'(12'o0004));

    send(1'b1, 3'd0, 18'o0, 1'b1, 5, 16'hBEEF, 1'b0, acc);
    send(1'b1, 3'd7, 18'o0, 1'b1, 5, 16'hFFFF, 1'b0, acc);
    drain();

    // Illegal write: error response, bus untouched.
    s0 = spec_cyc; d0 = drv_cyc;
    send(1'b0, 3'd0, 18'o123456, 1'b1, 1, 16'h0000, 1'b1, acc);
    drain();
    chk("illegal_no_strobe", 64'(spec_cyc - s0), 64'(0));
    chk("illegal_no_drive", 64'(drv_cyc - d0), 64'(0));

    send(1'b0, 3'd1, 18'o000003, 1'b1, 4, 16'h0000, 1'b0, acc);
    send(1'b0, 3'd3, 18'o777777, 1'b1, 4, 16'h0000, 1'b0, acc);
    drain();

    // Counter interrupt: hold word 16'h2000 selects EBOX (2); command waits for service.
    mem[7] = 16'h2000;
    hist = '0; r0 = rd_cyc;
    r = cyc;
    INTERRUPT_REQ = 1'b1;
    push_exp(1'b1, 16'h7FFF, 1'b0, 1'b0, 2'd2, r + 11);
    @(posedge clk); #1;
    INTERRUPT_REQ = 1'b0;
    @(posedge clk); #1;
    send(1'b1, 3'd4, 18'o0, 1'b1, 5, 16'h0123, 1'b0, acc);
    chk("cmd_after_service", 64'(acc), 64'(r + 12));
    drain();
    chk("irq_diag_seq", 64'(hist), 64'(12'o0724));
    chk("irq_rd_cycles", 64'(rd_cyc - r0), 64'(12));
    chk("irq_pending_cleared", 64'(irq_pending), 64'(0));

    // Vector interrupt, command already waiting when pending rises.
    mem[7] = 16'h8000;
    hist = '0; r0 = rd_cyc;
    r = cyc;
    INTERRUPT_REQ = 1'b1;
    push_exp(1'b1, 16'h0000, 1'b0, 1'b1, 2'd0, r + 6);
    @(posedge clk); #1;
    INTERRUPT_REQ = 1'b0;
    send(1'b0, 3'd1, 18'o000055, 1'b1, 4, 16'h0000, 1'b0, acc);
    chk("svc_beats_cmd", 64'(acc), 64'(r + 7));
    drain();
    chk("vec_single_read", 64'(hist), 64'(12'o0007));
    chk("vec_rd_cycles", 64'(rd_cyc - r0), 64'(4));

    // Reset in the middle of a read: strobes drop immediately, no response.
    send(1'b1, 3'd5, 18'o0, 1'b0, 5, 16'h0000, 1'b0, acc);
    @(posedge clk); #1;
    chk("rd_active_before_reset", 64'(READ_MTR), 64'(1));
    @(negedge clk);
    RESET_L = 1'b0;
    #1;
    chk("reset_mid_read",
        64'({READ_MTR, SPEC_MTR_CTL, ebus_drive, hb.rsp_valid, irq_valid}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) RESET_L = 1'b1;
    repeat (10) @(posedge clk); #1;

    drain();
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    chk("protocol_violations", 64'(viol), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
